// File: rtl/cap_xfer_seq_pkg.sv
// Shared types for the capability load/store sequencer.
// Fault codes, slot layout and FSM state encodings.
package cap_xfer_seq_pkg;

    localparam int CAP_FIELD_W = 48;
    localparam int NUM_SLOTS   = 6;

    localparam int SLOT_BASE  = 0;
    localparam int SLOT_LEN   = 1;
    localparam int SLOT_CUR   = 2;
    localparam int SLOT_PERMS = 3;
    localparam int SLOT_ATTR  = 4;
    localparam int SLOT_TAG   = 5;

    typedef enum logic [1:0] {
        FC_NONE   = 2'd0,
        FC_UNTAG  = 2'd1,
        FC_PERM   = 2'd2,
        FC_BOUNDS = 2'd3
    } fault_code_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_XFER  = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

endpackage

// File: rtl/cap_xfer_pack.sv
// Word-level view of a capability image in memory.
// Selects the store word by index and merges a loaded word into the assembly image.
module cap_xfer_pack
    import cap_xfer_seq_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 48,
    parameter int PERM_W = 24,
    parameter int CNT_W  = 4
) (
    input  logic [CNT_W-1:0]                       idx_i,
    input  logic [ADDR_W-1:0]                      src_base_i,
    input  logic [ADDR_W-1:0]                      src_len_i,
    input  logic [ADDR_W-1:0]                      src_cur_i,
    input  logic [PERM_W-1:0]                      src_perms_i,
    input  logic [PERM_W-1:0]                      src_attr_i,
    input  logic                                   src_tag_i,
    input  logic                                   cap_en_i,
    input  logic [DATA_W-1:0]                      rdata_i,
    input  logic [NUM_SLOTS*CAP_FIELD_W-1:0]       asm_i,
    output logic [DATA_W-1:0]                      wdata_o,
    output logic [NUM_SLOTS*CAP_FIELD_W-1:0]       asm_o
);

    localparam int FLAT_W = NUM_SLOTS * CAP_FIELD_W;

    logic [FLAT_W-1:0] img;

    // Store image: six zero-extended slots, word 0 of slot 0 at the lowest bits
    always_comb begin
        img = '0;
        img[SLOT_BASE*CAP_FIELD_W  +: CAP_FIELD_W] = CAP_FIELD_W'(src_base_i);
        img[SLOT_LEN*CAP_FIELD_W   +: CAP_FIELD_W] = CAP_FIELD_W'(src_len_i);
        img[SLOT_CUR*CAP_FIELD_W   +: CAP_FIELD_W] = CAP_FIELD_W'(src_cur_i);
        img[SLOT_PERMS*CAP_FIELD_W +: CAP_FIELD_W] = CAP_FIELD_W'(src_perms_i);
        img[SLOT_ATTR*CAP_FIELD_W  +: CAP_FIELD_W] = CAP_FIELD_W'(src_attr_i);
        img[SLOT_TAG*CAP_FIELD_W   +: CAP_FIELD_W] = CAP_FIELD_W'(src_tag_i);
        wdata_o = img[idx_i*DATA_W +: DATA_W];
    end

    // Load demux: drop the acked word into its slot position
    always_comb begin
        asm_o = asm_i;
        if (cap_en_i) begin
            asm_o[idx_i*DATA_W +: DATA_W] = rdata_i;
        end
    end

endmodule

// File: rtl/cap_xfer_seq.sv
// Multi-cycle capability load/store sequencer for the memory stage.
// Checks the authorising capability, then moves the capability one word per ack.
module cap_xfer_seq
    import cap_xfer_seq_pkg::*;
#(
    parameter int DATA_W  = 24,
    parameter int ADDR_W  = 48,
    parameter int PERM_W  = 24,
    parameter int PERM_SC = 1,
    parameter int PERM_LC = 2
) (
    input  logic              iw_clk,
    input  logic              iw_rst,
    input  logic              iw_start,
    input  logic              iw_is_load,
    input  logic [ADDR_W-1:0] iw_eff_addr,
    input  logic [ADDR_W-1:0] iw_auth_base,
    input  logic [ADDR_W-1:0] iw_auth_len,
    input  logic [PERM_W-1:0] iw_auth_perms,
    input  logic              iw_auth_tag,
    input  logic [ADDR_W-1:0] iw_src_base,
    input  logic [ADDR_W-1:0] iw_src_len,
    input  logic [ADDR_W-1:0] iw_src_cur,
    input  logic [PERM_W-1:0] iw_src_perms,
    input  logic [PERM_W-1:0] iw_src_attr,
    input  logic              iw_src_tag,
    input  logic              iw_flush,
    output logic              ow_mem_req,
    output logic              ow_mem_we,
    output logic [ADDR_W-1:0] ow_mem_addr,
    output logic [DATA_W-1:0] ow_mem_wdata,
    input  logic              iw_mem_ack,
    input  logic [DATA_W-1:0] iw_mem_rdata,
    output logic              ow_busy,
    output logic              ow_done,
    output logic              ow_fault,
    output logic [1:0]        ow_fault_code,
    output logic [ADDR_W-1:0] ow_ld_base,
    output logic [ADDR_W-1:0] ow_ld_len,
    output logic [ADDR_W-1:0] ow_ld_cur,
    output logic [PERM_W-1:0] ow_ld_perms,
    output logic [PERM_W-1:0] ow_ld_attr,
    output logic              ow_ld_tag
);

    localparam int SW     = CAP_FIELD_W / DATA_W;
    localparam int NW     = NUM_SLOTS * SW;
    localparam int CNT_W  = $clog2(NW);
    localparam int FLAT_W = NUM_SLOTS * CAP_FIELD_W;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    fault_code_e        code_q, code_d;

    logic               is_load_q;
    logic               perm_ok_q;
    logic               atag_q;
    logic [ADDR_W-1:0]  eff_q;
    logic [ADDR_W-1:0]  abase_q;
    logic [ADDR_W-1:0]  alen_q;
    logic [ADDR_W-1:0]  sbase_q;
    logic [ADDR_W-1:0]  slen_q;
    logic [ADDR_W-1:0]  scur_q;
    logic [PERM_W-1:0]  sperms_q;
    logic [PERM_W-1:0]  sattr_q;
    logic               stag_q;
    logic [FLAT_W-1:0]  asm_q, asm_d;

    logic [ADDR_W-1:0]  ld_base_q, ld_len_q, ld_cur_q;
    logic [PERM_W-1:0]  ld_perms_q, ld_attr_q;
    logic               ld_tag_q;

    logic               start_ok;
    logic               last_word;
    logic               cap_en;
    logic               ld_upd;
    logic               oob;
    logic [ADDR_W:0]    end_req;
    logic [ADDR_W:0]    end_auth;
    logic [DATA_W-1:0]  wdata_sel;

    assign start_ok  = (state_q == ST_IDLE) && iw_start;
    assign last_word = (cnt_q == CNT_W'(NW - 1));
    assign cap_en    = (state_q == ST_XFER) && iw_mem_ack && is_load_q && !iw_flush;
    assign ld_upd    = cap_en && last_word;

    // One extra bit so a window running past the top of the address space faults
    assign end_req  = {1'b0, eff_q} + (ADDR_W+1)'(NW);
    assign end_auth = {1'b0, abase_q} + {1'b0, alen_q};
    assign oob      = (eff_q < abase_q) || (end_req > end_auth);

    cap_xfer_pack #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .PERM_W (PERM_W),
        .CNT_W  (CNT_W)
    ) u_pack (
        .idx_i       (cnt_q),
        .src_base_i  (sbase_q),
        .src_len_i   (slen_q),
        .src_cur_i   (scur_q),
        .src_perms_i (sperms_q),
        .src_attr_i  (sattr_q),
        .src_tag_i   (stag_q),
        .cap_en_i    (cap_en),
        .rdata_i     (iw_mem_rdata),
        .asm_i       (asm_q),
        .wdata_o     (wdata_sel),
        .asm_o       (asm_d)
    );

    // Control state, word counter and sticky fault code
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            code_q  <= FC_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    // Operands captured on an accepted start; assembly image fills on load acks
    always_ff @(posedge iw_clk) begin
        if (start_ok) begin
            is_load_q <= iw_is_load;
            perm_ok_q <= iw_is_load ? iw_auth_perms[PERM_LC] : iw_auth_perms[PERM_SC];
            atag_q    <= iw_auth_tag;
            eff_q     <= iw_eff_addr;
            abase_q   <= iw_auth_base;
            alen_q    <= iw_auth_len;
            sbase_q   <= iw_src_base;
            slen_q    <= iw_src_len;
            scur_q    <= iw_src_cur;
            sperms_q  <= iw_src_perms;
            sattr_q   <= iw_src_attr;
            stag_q    <= iw_src_tag;
        end
        if (cap_en) begin
            asm_q <= asm_d;
        end
    end

    // Loaded capability only becomes visible once the last word lands
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            ld_base_q  <= '0;
            ld_len_q   <= '0;
            ld_cur_q   <= '0;
            ld_perms_q <= '0;
            ld_attr_q  <= '0;
            ld_tag_q   <= 1'b0;
        end else if (ld_upd) begin
            ld_base_q  <= asm_d[SLOT_BASE*CAP_FIELD_W  +: ADDR_W];
            ld_len_q   <= asm_d[SLOT_LEN*CAP_FIELD_W   +: ADDR_W];
            ld_cur_q   <= asm_d[SLOT_CUR*CAP_FIELD_W   +: ADDR_W];
            ld_perms_q <= asm_d[SLOT_PERMS*CAP_FIELD_W +: PERM_W];
            ld_attr_q  <= asm_d[SLOT_ATTR*CAP_FIELD_W  +: PERM_W];
            ld_tag_q   <= asm_d[SLOT_TAG*CAP_FIELD_W] & atag_q;
        end
    end

    // Next-state, counter and pulse outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        code_d     = code_q;
        ow_busy    = 1'b0;
        ow_done    = 1'b0;
        ow_fault   = 1'b0;
        ow_mem_req = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (iw_start) begin
                    state_d = ST_CHECK;
                    code_d  = FC_NONE;
                    cnt_d   = '0;
                end
            end
            ST_CHECK: begin
                ow_busy = 1'b1;
                cnt_d   = '0;
                if (iw_flush) begin
                    state_d = ST_IDLE;
                end else if (!atag_q) begin
                    state_d = ST_FAULT;
                    code_d  = FC_UNTAG;
                end else if (!perm_ok_q) begin
                    state_d = ST_FAULT;
                    code_d  = FC_PERM;
                end else if (oob) begin
                    state_d = ST_FAULT;
                    code_d  = FC_BOUNDS;
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                ow_busy    = 1'b1;
                ow_mem_req = 1'b1;
                if (iw_flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (iw_mem_ack) begin
                    if (last_word) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                ow_done = 1'b1;
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                ow_fault = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ow_mem_we     = ow_mem_req && !is_load_q;
    assign ow_mem_addr   = ow_mem_req ? (eff_q + ADDR_W'(cnt_q)) : '0;
    assign ow_mem_wdata  = ow_mem_we ? wdata_sel : '0;
    assign ow_fault_code = code_q;

    assign ow_ld_base  = ld_base_q;
    assign ow_ld_len   = ld_len_q;
    assign ow_ld_cur   = ld_cur_q;
    assign ow_ld_perms = ld_perms_q;
    assign ow_ld_attr  = ld_attr_q;
    assign ow_ld_tag   = ld_tag_q;

    // Only the selected permission bit and the low bits of each slot matter
    logic unused_bits;
    assign unused_bits = ^{iw_auth_perms, asm_d};

endmodule

// File: tb/tb_cap_xfer_seq.sv
// Self-checking bench for cap_xfer_seq.
// Vector table plus scoreboard for done/fault pulses and hand-written corner sequences.
module tb_cap_xfer_seq;

    localparam int NW = 12;

    typedef struct packed {
        logic [47:0] base;
        logic [47:0] len;
        logic [47:0] cur;
        logic [23:0] perms;
        logic [23:0] attr;
        logic        tag;
    } cap_t;

    typedef struct {
        string       name;
        bit          is_load;
        logic [47:0] abase;
        logic [47:0] alen;
        logic [23:0] aperms;
        bit          atag;
        logic [47:0] eff;
        logic [1:0]  code;
        cap_t        ld;
    } vec_t;

    typedef struct {
        bit         is_fault;
        logic [1:0] code;
        bit         is_load;
        cap_t       ld;
    } exp_t;

    logic        clk, rst, start, is_load, atag, flush;
    logic [47:0] eff, abase, alen;
    logic [23:0] aperms;
    cap_t        src;
    logic        req, we, ack, busy, done, fault;
    logic [47:0] addr;
    logic [23:0] wdata, rdata;
    logic [1:0]  fcode;
    logic [47:0] ld_base, ld_len, ld_cur;
    logic [23:0] ld_perms, ld_attr;
    logic        ld_tag;

    logic        w_start, w_req, w_we, w_busy, w_done, w_fault, w_ld_tag;
    logic [47:0] w_addr, w_wdata, w_ld_base, w_ld_len, w_ld_cur;
    logic [23:0] w_ld_perms, w_ld_attr;
    logic [1:0]  w_code;

    int checks = 0;
    int fails  = 0;
    exp_t sb[$];

    logic [23:0] mem   [0:1023];
    logic [47:0] mem48 [0:15];
    int          req_seen;
    bit          stall_en;
    int          stall_left;
    bit          block_en;
    logic [47:0] block_addr;
    int          unstable;
    bit          pend_v;
    logic [47:0] pend_addr;
    logic [23:0] pend_wdata;

    cap_xfer_seq dut (
        .iw_clk(clk), .iw_rst(rst), .iw_start(start), .iw_is_load(is_load),
        .iw_eff_addr(eff), .iw_auth_base(abase), .iw_auth_len(alen),
        .iw_auth_perms(aperms), .iw_auth_tag(atag),
        .iw_src_base(src.base), .iw_src_len(src.len), .iw_src_cur(src.cur),
        .iw_src_perms(src.perms), .iw_src_attr(src.attr), .iw_src_tag(src.tag),
        .iw_flush(flush), .ow_mem_req(req), .ow_mem_we(we), .ow_mem_addr(addr),
        .ow_mem_wdata(wdata), .iw_mem_ack(ack), .iw_mem_rdata(rdata),
        .ow_busy(busy), .ow_done(done), .ow_fault(fault), .ow_fault_code(fcode),
        .ow_ld_base(ld_base), .ow_ld_len(ld_len), .ow_ld_cur(ld_cur),
        .ow_ld_perms(ld_perms), .ow_ld_attr(ld_attr), .ow_ld_tag(ld_tag)
    );

    cap_xfer_seq #(.DATA_W(48)) dut48 (
        .iw_clk(clk), .iw_rst(rst), .iw_start(w_start), .iw_is_load(is_load),
        .iw_eff_addr(eff), .iw_auth_base(abase), .iw_auth_len(alen),
        .iw_auth_perms(aperms), .iw_auth_tag(atag),
        .iw_src_base(src.base), .iw_src_len(src.len), .iw_src_cur(src.cur),
        .iw_src_perms(src.perms), .iw_src_attr(src.attr), .iw_src_tag(src.tag),
        .iw_flush(1'b0), .ow_mem_req(w_req), .ow_mem_we(w_we), .ow_mem_addr(w_addr),
        .ow_mem_wdata(w_wdata), .iw_mem_ack(w_req), .iw_mem_rdata(48'h0),
        .ow_busy(w_busy), .ow_done(w_done), .ow_fault(w_fault), .ow_fault_code(w_code),
        .ow_ld_base(w_ld_base), .ow_ld_len(w_ld_len), .ow_ld_cur(w_ld_cur),
        .ow_ld_perms(w_ld_perms), .ow_ld_attr(w_ld_attr), .ow_ld_tag(w_ld_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [47:0] slot_val(cap_t c, int s);
        case (s)
            0: return c.base;
            1: return c.len;
            2: return c.cur;
            3: return {24'h0, c.perms};
            4: return {24'h0, c.attr};
            default: return {47'h0, c.tag};
        endcase
    endfunction

    function automatic logic [47:0] word_of(cap_t c, int k, int dw);
        int sw;
        logic [47:0] v;
        sw = 48 / dw;
        v  = slot_val(c, k / sw) >> ((k % sw) * dw);
        if (dw < 48) v = v & ((48'h1 << dw) - 48'h1);
        return v;
    endfunction

    // Word memory: optional random stall, per-address hold-off, stability tracking
    always @(negedge clk) begin
        if (req) begin
            req_seen++;
            if (pend_v && (addr !== pend_addr || wdata !== pend_wdata)) unstable++;
            if (block_en && addr == block_addr) begin
                ack = 1'b0;
            end else if (stall_left > 0) begin
                ack = 1'b0;
                stall_left--;
            end else begin
                ack = 1'b1;
            end
            rdata = mem[addr[9:0]];
            if (ack) begin
                if (we) mem[addr[9:0]] = wdata;
                pend_v = 1'b0;
                if (stall_en) stall_left = $urandom_range(0, 3);
            end else begin
                pend_v     = 1'b1;
                pend_addr  = addr;
                pend_wdata = wdata;
            end
        end else begin
            ack    = 1'b0;
            pend_v = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (w_req && w_we) mem48[w_addr[3:0]] = w_wdata;
    end

    // Scoreboard: every done/fault pulse must match the oldest expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (done || fault) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_pulse: done=%0b fault=%0b, required no pulse", done, fault);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind", {done, fault}, e.is_fault ? 2'b01 : 2'b10);
                chk("busy_at_pulse", busy, 1'b0);
                if (e.is_fault) chk("fault_code", fcode, e.code);
                else if (e.is_load)
                    chk("ld_cap", {ld_base, ld_len, ld_cur, ld_perms, ld_attr, ld_tag}, e.ld);
            end
        end
    end

    task automatic push_exp(input bit ld, input logic [1:0] code, input cap_t c);
        exp_t e;
        e.is_fault = (code != 2'd0);
        e.code     = code;
        e.is_load  = ld;
        e.ld       = c;
        sb.push_back(e);
    endtask

    // Called at a negedge in an idle cycle; returns at a negedge in the next idle cycle
    task automatic run_op(input bit ld, input logic [47:0] ef, input logic [47:0] ab,
                          input logic [47:0] al, input logic [23:0] ap, input bit at,
                          output int cyc);
        is_load    = ld;
        eff        = ef;
        abase      = ab;
        alen       = al;
        aperms     = ap;
        atag       = at;
        req_seen   = 0;
        stall_left = stall_en ? $urandom_range(0, 3) : 0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        chk("busy_cycle1", busy, 1'b1);
        while (!(done || fault) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 200) begin
            checks++;
            fails++;
            $display("FAIL op_timeout: no done/fault after %0d cycles", cyc);
        end
        @(negedge clk);
    endtask

    vec_t tv[15];
    cap_t src1, cap2, cap3, none;

    function automatic vec_t mkv(string n, bit ld, logic [47:0] ab, logic [47:0] al,
                                 logic [23:0] ap, bit at, logic [47:0] ef,
                                 logic [1:0] cd, cap_t c);
        vec_t v;
        v.name = n; v.is_load = ld; v.abase = ab; v.alen = al; v.aperms = ap;
        v.atag = at; v.eff = ef; v.code = cd; v.ld = c;
        return v;
    endfunction

    initial begin : main
        int cyc;
        int t;
        src1 = '{base: 48'd1234, len: 48'd5678, cur: 48'd91011,
                 perms: 24'h00ABCD, attr: 24'h001122, tag: 1'b1};
        cap2 = '{base: 48'hABCDEF123456, len: 48'h000001000000, cur: 48'h7F000000FFFF,
                 perms: 24'h00F00D, attr: 24'h00BEEF, tag: 1'b1};
        cap3 = cap2;
        cap3.tag = 1'b0;
        none = '0;

        tv[0]  = mkv("st_basic",  0, 0,   1024, 24'h2, 1, 300, 2'd0, none);
        tv[1]  = mkv("ld_basic",  1, 0,   1024, 24'h4, 1, 300, 2'd0, src1);
        tv[2]  = mkv("ld_untag",  1, 0,   1024, 24'h4, 0, 300, 2'd1, none);
        tv[3]  = mkv("st_noperm", 0, 0,   1024, 24'h4, 1, 300, 2'd2, none);
        tv[4]  = mkv("ld_noperm", 1, 0,   1024, 24'h2, 1, 300, 2'd2, none);
        tv[5]  = mkv("st_oob_hi", 0, 200, 100,  24'h2, 1, 290, 2'd3, none);
        tv[6]  = mkv("st_inb",    0, 200, 100,  24'h2, 1, 288, 2'd0, none);
        tv[7]  = mkv("ld_inb",    1, 200, 100,  24'h4, 1, 288, 2'd0, src1);
        tv[8]  = mkv("st_oob_lo", 0, 500, 100,  24'h2, 1, 499, 2'd3, none);
        tv[9]  = mkv("prio_tag",  0, 500, 100,  24'h0, 0, 499, 2'd1, none);
        tv[10] = mkv("prio_perm", 0, 0,   1024, 24'h0, 1, 2000, 2'd2, none);
        tv[11] = mkv("st_nowrap", 0, 0, 48'hFFFFFFFFFFFF, 24'h2, 1, 48'hFFFFFFFFFFFA, 2'd3, none);
        tv[12] = mkv("ld_tag1",   1, 0,   1024, 24'h6, 1, 400, 2'd0, cap2);
        tv[13] = mkv("ld_tag0",   1, 0,   1024, 24'h6, 1, 420, 2'd0, cap3);
        tv[14] = mkv("st_exact",  0, 200, 12,   24'h2, 1, 200, 2'd0, none);

        for (int i = 0; i < 1024; i++) mem[i] = 24'h0;
        for (int i = 0; i < 16; i++) mem48[i] = 48'h0;
        for (int k = 0; k < NW; k++) begin
            mem[400+k] = word_of(cap2, k, 24);
            mem[420+k] = word_of(cap2, k, 24);
        end
        mem[407] = 24'h0000FF; mem[409] = 24'h123456;
        mem[410] = 24'hFFFFFF; mem[411] = 24'h00ABCD;
        mem[427] = 24'h0000FF; mem[429] = 24'h123456;
        mem[430] = 24'hFFFFFE; mem[431] = 24'h00ABCD;
        for (int k = 700; k < 712; k++) mem[k] = 24'hEEEEEE;

        ack = 0; rdata = 0; stall_en = 0; stall_left = 0; block_en = 0;
        block_addr = 0; unstable = 0; pend_v = 0; req_seen = 0;
        start = 0; w_start = 0; flush = 0; is_load = 0; atag = 0;
        eff = 0; abase = 0; alen = 0; aperms = 0; src = src1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req", {req, we, addr, wdata}, '0);
        chk("rst_pulses", {done, fault, fcode}, '0);
        chk("rst_ld", {ld_base, ld_len, ld_cur, ld_perms, ld_attr, ld_tag}, '0);
        rst = 1'b0;
        @(negedge clk);

        foreach (tv[i]) begin
            push_exp(tv[i].is_load, tv[i].code, tv[i].ld);
            run_op(tv[i].is_load, tv[i].eff, tv[i].abase, tv[i].alen,
                   tv[i].aperms, tv[i].atag, cyc);
            chk({tv[i].name, "_reqs"}, req_seen, (tv[i].code == 0) ? NW : 0);
            if (tv[i].code == 0) chk({tv[i].name, "_latency"}, cyc, 14);
        end
        for (int k = 0; k < NW; k++) chk("st_basic_mem", mem[300+k], word_of(src1, k, 24));

        // Random ack stalls: bus must hold still and the image must match
        stall_en = 1;
        push_exp(0, 2'd0, none);
        run_op(0, 600, 0, 1024, 24'h2, 1, cyc);
        stall_en = 0;
        chk("stall_stable", unstable, 0);
        chk("stall_reqs_ge", req_seen >= NW, 1'b1);
        for (int k = 0; k < NW; k++) chk("stall_mem", mem[600+k], word_of(src1, k, 24));

        // Flush while word 5 is outstanding
        block_en = 1; block_addr = 705;
        is_load = 0; eff = 700; abase = 0; alen = 1024; aperms = 24'h2; atag = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!(req && addr == 48'd705) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("flush_reached_w5", t < 100, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        block_en = 0;
        chk("flush_busy", busy, 1'b0);
        chk("flush_req", req, 1'b0);
        for (int k = 0; k < NW; k++)
            chk("flush_mem", mem[700+k], (k < 5) ? word_of(src1, k, 24) : 48'hEEEEEE);
        push_exp(0, 2'd0, none);
        run_op(0, 700, 0, 1024, 24'h2, 1, cyc);
        chk("restart_latency", cyc, 14);
        for (int k = 5; k < NW; k++) chk("restart_mem", mem[700+k], word_of(src1, k, 24));

        // Fault code holds until start; reset mid-operation clears it
        push_exp(0, 2'd3, none);
        run_op(0, 290, 200, 100, 24'h2, 1, cyc);
        chk("code_held", fcode, 2'd3);
        is_load = 0; eff = 800; abase = 0; alen = 1024; aperms = 24'h2; atag = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("code_clr_start", fcode, 2'd0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy_req", {busy, req}, 2'b00);
        push_exp(0, 2'd1, none);
        run_op(0, 300, 0, 1024, 24'h2, 0, cyc);
        chk("code_held2", fcode, 2'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("code_clr_rst", fcode, 2'd0);

        // 48-bit word build: six words, done at cycle 8
        is_load = 0; eff = 4; abase = 0; alen = 1024; aperms = 24'h2; atag = 1;
        w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        cyc = 1;
        while (!w_done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("w48_latency", cyc, 8);
        for (int k = 0; k < 6; k++) chk("w48_mem", mem48[4+k], word_of(src1, k, 48));
        @(negedge clk);

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
